// File: rtl/unstripe_deskew.sv
// Receive-side lane merger: two independent 32-bit lanes are buffered in small
// per-lane FIFOs and re-serialised strictly as lane0, lane1, lane0, lane1, ...
module unstripe_deskew #(
   parameter int BUS_WIDTH = 32,
   parameter int DEPTH     = 4
) (
   input  logic                 clk_2f,
   input  logic                 reset,
   input  logic [BUS_WIDTH-1:0] lane0,
   input  logic                 valid0,
   input  logic [BUS_WIDTH-1:0] lane1,
   input  logic                 valid1,
   output logic [BUS_WIDTH-1:0] dataOut,
   output logic                 validOut,
   output logic                 overflow0,
   output logic                 overflow1,
   output logic                 o_state_dbg
);

   localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic {
      WAIT_L0 = 1'b0,
      WAIT_L1 = 1'b1
   } state_t;

   state_t               r_state;
   logic [BUS_WIDTH-1:0] r_mem [2][DEPTH];
   logic [AW-1:0]        r_wp  [2];
   logic [AW-1:0]        r_rp  [2];
   logic [AW:0]          r_cnt [2];
   logic [1:0]           r_ovf;
   logic [BUS_WIDTH-1:0] r_data;
   logic                 r_valid;

   logic [BUS_WIDTH-1:0] w_in [2];
   logic [1:0]           w_vin;
   logic [1:0]           w_pop;
   logic [1:0]           w_push;
   logic [1:0]           w_drop;
   logic [BUS_WIDTH-1:0] w_head;

   // Lane handshake: a word is offered when validN=1; it is taken unless the
   // FIFO is full, where a same-edge pop frees the slot. No backpressure exists,
   // so a refused word is lost and flagged on overflowN.
   always_comb begin
      w_in[0]  = lane0;
      w_in[1]  = lane1;
      w_vin    = {valid1, valid0};
      w_pop    = '0;
      w_push   = '0;
      w_drop   = '0;
      w_pop[0] = (r_state == WAIT_L0) && (r_cnt[0] != '0);
      w_pop[1] = (r_state == WAIT_L1) && (r_cnt[1] != '0);
      for (int i = 0; i < 2; i++) begin
         w_push[i] = w_vin[i] && ((r_cnt[i] != FULL_CNT) || w_pop[i]);
         w_drop[i] = w_vin[i] && !w_push[i];
      end
      w_head = (r_state == WAIT_L0) ? r_mem[0][r_rp[0]] : r_mem[1][r_rp[1]];
   end

   // Storage needs no reset: occupancy is tracked entirely by the counters.
   always_ff @(posedge clk_2f) begin
      for (int i = 0; i < 2; i++) begin
         if (w_push[i]) begin
            r_mem[i][r_wp[i]] <= w_in[i];
         end
      end
   end

   always_ff @(posedge clk_2f or posedge reset) begin
      if (reset) begin
         r_state <= WAIT_L0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ovf   <= '0;
         for (int i = 0; i < 2; i++) begin
            r_wp[i]  <= '0;
            r_rp[i]  <= '0;
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (w_push[i]) begin
               r_wp[i] <= r_wp[i] + AW'(1);
            end
            if (w_pop[i]) begin
               r_rp[i] <= r_rp[i] + AW'(1);
            end
            case ({w_push[i], w_pop[i]})
               2'b10:   r_cnt[i] <= r_cnt[i] + (AW+1)'(1);
               2'b01:   r_cnt[i] <= r_cnt[i] - (AW+1)'(1);
               default: r_cnt[i] <= r_cnt[i];
            endcase
            if (w_drop[i]) begin
               r_ovf[i] <= 1'b1;
            end
         end

         case (r_state)
            WAIT_L0: begin
               if (w_pop[0]) begin
                  r_data  <= w_head;
                  r_valid <= 1'b1;
                  r_state <= WAIT_L1;
               end else begin
                  r_valid <= 1'b0;
               end
            end
            WAIT_L1: begin
               if (w_pop[1]) begin
                  r_data  <= w_head;
                  r_valid <= 1'b1;
                  r_state <= WAIT_L0;
               end else begin
                  r_valid <= 1'b0;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= WAIT_L0;
            end
         endcase
      end
   end

   assign dataOut     = r_data;
   assign validOut    = r_valid;
   assign overflow0   = r_ovf[0];
   assign overflow1   = r_ovf[1];
   assign o_state_dbg = r_state;

endmodule
